stump_control: RTL and testbench

//  Stump control unit: drives fetch/execute/memory sequencing and decodes the IR into ALU and datapath controls.
//  Its func/c_in outputs and the operand-select outputs feed the ALU and shifter directly.

---
 rtl/stump_control_pkg.sv | 66 ++++++
 rtl/stump_cond_eval.sv | 38 +++
 rtl/stump_control.sv | 149 ++++++++++++++
 tb/tb_stump_control.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stump_control_pkg.sv
// Shared encodings for the Stump control unit: states, opcodes, conditions, operand-B selects.
// No logic; pure type and constant definitions.
// No flow control.
package stump_control_pkg;

    localparam int IR_W     = 16;
    localparam int NUM_COND = 16;
    localparam int COND_W   = $clog2(NUM_COND);

    localparam logic [2:0] REG_PC = 3'd7;

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_EXECUTE = 2'd1,
        ST_MEMORY  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_ADC  = 3'd1,
        OP_SUB  = 3'd2,
        OP_SBC  = 3'd3,
        OP_AND  = 3'd4,
        OP_OR   = 3'd5,
        OP_LDST = 3'd6,
        OP_BCC  = 3'd7
    } op_t;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,
        COND_NV = 4'd1,
        COND_HI = 4'd2,
        COND_LS = 4'd3,
        COND_CC = 4'd4,
        COND_CS = 4'd5,
        COND_NE = 4'd6,
        COND_EQ = 4'd7,
        COND_VC = 4'd8,
        COND_VS = 4'd9,
        COND_PL = 4'd10,
        COND_MI = 4'd11,
        COND_GE = 4'd12,
        COND_LT = 4'd13,
        COND_GT = 4'd14,
        COND_LE = 4'd15
    } cond_t;

    typedef enum logic [1:0] {
        OPB_REG  = 2'd0,
        OPB_IMM5 = 2'd1,
        OPB_IMM8 = 2'd2
    } opb_sel_t;

    // Field view of the instruction word; Bcc reuses {s_st, rd} as its condition code.
    typedef struct packed {
        op_t        op;
        logic       imm;
        logic       s_st;
        logic [2:0] rd;
        logic [2:0] ra;
        logic [2:0] rb;
        logic [1:0] sh;
    } ir_t;

endpackage

// File: rtl/stump_cond_eval.sv
// Branch condition evaluator: cond code + {N,Z,V,C} -> taken.
// Purely combinational, zero latency.
// No flow control.
module stump_cond_eval
    import stump_control_pkg::*;
(
    input  logic [COND_W-1:0] cond,
    input  logic [3:0]        cc,
    output logic              cond_true
);

    logic n, z, v, c;
    assign {n, z, v, c} = cc;

    always_comb begin
        cond_true = 1'b0;
        case (cond_t'(cond))
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            COND_HI: cond_true = ~c & ~z;
            COND_LS: cond_true = c | z;
            COND_CC: cond_true = ~c;
            COND_CS: cond_true = c;
            COND_NE: cond_true = ~z;
            COND_EQ: cond_true = z;
            COND_VC: cond_true = ~v;
            COND_VS: cond_true = v;
            COND_PL: cond_true = ~n;
            COND_MI: cond_true = n;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: rtl/stump_control.sv
// Stump control unit: FETCH/EXECUTE/MEMORY sequencer, IR decode, NZVC register, branch test.
// ALU ops take 2 cycles, LD/ST 3 plus memory wait cycles; controls are combinational from state+ir.
// FETCH and MEMORY hold while mem_ready is low; EXECUTE never stalls.
module stump_control
    import stump_control_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir,
    input  logic [3:0]      flags_in,
    input  logic            mem_ready,
    output logic [1:0]      state,
    output logic            ir_en,
    output logic            pc_inc,
    output logic            mem_ren,
    output logic            mem_wen,
    output logic            addr_sel,
    output logic            addr_en,
    output logic [2:0]      alu_func,
    output logic            c_in,
    output logic [1:0]      opB_sel,
    output logic [1:0]      shift_op,
    output logic [2:0]      srcA,
    output logic [2:0]      srcB,
    output logic [2:0]      srcC,
    output logic [2:0]      dest,
    output logic            reg_write,
    output logic            wb_sel,
    output logic [3:0]      cc
);

    state_t     state_q, state_d;
    logic [3:0] cc_q;
    logic       cc_ld;
    logic       cond_true;
    ir_t        d;

    assign d     = ir_t'(ir);
    assign state = state_q;
    assign cc    = cc_q;

    stump_cond_eval u_cond_eval (
        .cond      ({d.s_st, d.rd}),
        .cc        (cc_q),
        .cond_true (cond_true)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= 4'b0000;
        end else if (cc_ld) begin
            cc_q <= flags_in;
        end
    end

    always_comb begin
        state_d   = state_q;
        cc_ld     = 1'b0;
        ir_en     = 1'b0;
        pc_inc    = 1'b0;
        mem_ren   = 1'b0;
        mem_wen   = 1'b0;
        addr_sel  = 1'b0;
        addr_en   = 1'b0;
        alu_func  = OP_ADD;
        c_in      = 1'b0;
        opB_sel   = OPB_REG;
        shift_op  = 2'b00;
        srcA      = 3'd0;
        srcB      = 3'd0;
        srcC      = 3'd0;
        dest      = 3'd0;
        reg_write = 1'b0;
        wb_sel    = 1'b0;

        case (state_q)
            ST_FETCH: begin
                // PC only advances on the cycle the fetch is actually accepted.
                mem_ren = 1'b1;
                ir_en   = mem_ready;
                pc_inc  = mem_ready;
                if (mem_ready) begin
                    state_d = ST_EXECUTE;
                end
            end

            ST_EXECUTE: begin
                state_d = (d.op == OP_LDST) ? ST_MEMORY : ST_FETCH;
                srcA    = d.ra;
                srcB    = d.rb;
                case (d.op)
                    OP_LDST: begin
                        alu_func = OP_ADD;
                        opB_sel  = d.imm ? OPB_IMM5 : OPB_REG;
                        addr_en  = 1'b1;
                    end
                    OP_BCC: begin
                        // Branch target = PC(R7) + sext(offset8), written back only if taken.
                        srcA      = REG_PC;
                        srcB      = 3'd0;
                        alu_func  = OP_ADD;
                        opB_sel   = OPB_IMM8;
                        dest      = REG_PC;
                        reg_write = cond_true;
                    end
                    default: begin
                        alu_func  = d.op;
                        reg_write = 1'b1;
                        dest      = d.rd;
                        opB_sel   = d.imm ? OPB_IMM5 : OPB_REG;
                        shift_op  = d.imm ? 2'b00 : d.sh;
                        c_in      = cc_q[0] & ((d.op == OP_ADC) || (d.op == OP_SBC));
                        cc_ld     = d.s_st;
                    end
                endcase
            end

            ST_MEMORY: begin
                addr_sel = 1'b1;
                if (d.s_st) begin
                    mem_wen = 1'b1;
                    srcC    = d.rd;
                end else begin
                    // Write-back select follows the write enable so it is only seen on the data cycle.
                    mem_ren   = 1'b1;
                    dest      = d.rd;
                    reg_write = mem_ready;
                    wb_sel    = mem_ready;
                end
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_stump_control.sv
// Directed bench for stump_control: expected output vectors queued per cycle,
// a negedge monitor pops and compares them against the DUT.
module tb_stump_control;

    typedef struct packed {
        logic [1:0] state;
        logic       ir_en;
        logic       pc_inc;
        logic       mem_ren;
        logic       mem_wen;
        logic       addr_sel;
        logic       addr_en;
        logic [2:0] alu_func;
        logic       c_in;
        logic [1:0] opB_sel;
        logic [1:0] shift_op;
        logic [2:0] srcA;
        logic [2:0] srcB;
        logic [2:0] srcC;
        logic [2:0] dest;
        logic       reg_write;
        logic       wb_sel;
        logic [3:0] cc;
    } out_t;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic [3:0]  flags_in;
    logic        mem_ready;
    logic [1:0]  state;
    logic        ir_en, pc_inc, mem_ren, mem_wen, addr_sel, addr_en;
    logic [2:0]  alu_func;
    logic        c_in;
    logic [1:0]  opB_sel, shift_op;
    logic [2:0]  srcA, srcB, srcC, dest;
    logic        reg_write, wb_sel;
    logic [3:0]  cc;

    out_t  exp_q[$];
    string name_q[$];
    int    n_cmp;
    int    n_bad;

    stump_control dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .flags_in  (flags_in),
        .mem_ready (mem_ready),
        .state     (state),
        .ir_en     (ir_en),
        .pc_inc    (pc_inc),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .addr_sel  (addr_sel),
        .addr_en   (addr_en),
        .alu_func  (alu_func),
        .c_in      (c_in),
        .opB_sel   (opB_sel),
        .shift_op  (shift_op),
        .srcA      (srcA),
        .srcB      (srcB),
        .srcC      (srcC),
        .dest      (dest),
        .reg_write (reg_write),
        .wb_sel    (wb_sel),
        .cc        (cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic out_t fetch_o(input logic rdy, input logic [3:0] c);
        out_t o = '0;
        o.state   = 2'd0;
        o.mem_ren = 1'b1;
        o.ir_en   = rdy;
        o.pc_inc  = rdy;
        o.cc      = c;
        return o;
    endfunction

    function automatic out_t exec_o(input logic [2:0] alu, input logic cin, input logic [1:0] opb,
                                    input logic [1:0] sh, input logic [2:0] sa, input logic [2:0] sb,
                                    input logic [2:0] dst, input logic rw, input logic aen,
                                    input logic [3:0] c);
        out_t o = '0;
        o.state     = 2'd1;
        o.alu_func  = alu;
        o.c_in      = cin;
        o.opB_sel   = opb;
        o.shift_op  = sh;
        o.srcA      = sa;
        o.srcB      = sb;
        o.dest      = dst;
        o.reg_write = rw;
        o.addr_en   = aen;
        o.cc        = c;
        return o;
    endfunction

    function automatic out_t mem_o(input logic ren, input logic wen, input logic [2:0] sc,
                                   input logic [2:0] dst, input logic rw, input logic wb,
                                   input logic [3:0] c);
        out_t o = '0;
        o.state     = 2'd2;
        o.addr_sel  = 1'b1;
        o.mem_ren   = ren;
        o.mem_wen   = wen;
        o.srcC      = sc;
        o.dest      = dst;
        o.reg_write = rw;
        o.wb_sel    = wb;
        o.cc        = c;
        return o;
    endfunction

    task automatic set_in(input logic r, input logic rdy, input logic [15:0] i, input logic [3:0] f);
        rst       = r;
        mem_ready = rdy;
        ir        = i;
        flags_in  = f;
    endtask

    task automatic cyc(input string nm, input out_t e);
        name_q.push_back(nm);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            out_t  e;
            out_t  a;
            string nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {state, ir_en, pc_inc, mem_ren, mem_wen, addr_sel, addr_en, alu_func, c_in,
                  opB_sel, shift_op, srcA, srcB, srcC, dest, reg_write, wb_sel, cc};
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got state=%0d rw=%0b wb=%0b wen=%0b cc=%b vec=%h, want state=%0d rw=%0b wb=%0b wen=%0b cc=%b vec=%h",
                         nm, a.state, a.reg_write, a.wb_sel, a.mem_wen, a.cc, a,
                         e.state, e.reg_write, e.wb_sel, e.mem_wen, e.cc, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        set_in(1'b1, 1'b1, 16'h0000, 4'h0);
        @(posedge clk);
        #1;

        // Reset and a plain ADD (no S): 0 -> 1 -> 0, cc untouched.
        cyc("reset",        fetch_o(1'b1, 4'h0));
        set_in(1'b0, 1'b1, 16'h0000, 4'hF);
        cyc("rel_fetch",    fetch_o(1'b1, 4'h0));
        cyc("add_nos_exec", exec_o(3'd0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4'h0));

        // ADD R1,R2,R3 with S after a stalled fetch.
        set_in(1'b0, 1'b0, 16'h094C, 4'h5);
        cyc("fetch_stall",  fetch_o(1'b0, 4'h0));
        set_in(1'b0, 1'b1, 16'h094C, 4'h5);
        cyc("fetch_go",     fetch_o(1'b1, 4'h0));
        cyc("add_s_exec",   exec_o(3'd0, 1'b0, 2'd0, 2'd0, 3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 4'h0));

        // BEQ taken (Z=1), flags_in must not leak into cc.
        set_in(1'b0, 1'b1, 16'hF704, 4'hA);
        cyc("fetch_cc5",    fetch_o(1'b1, 4'h5));
        cyc("beq_taken",    exec_o(3'd0, 1'b0, 2'd2, 2'd0, 3'd7, 3'd0, 3'd7, 1'b1, 1'b0, 4'h5));

        // ADD S clears cc, then BEQ not taken.
        set_in(1'b0, 1'b1, 16'h0800, 4'h0);
        cyc("fetch_a",      fetch_o(1'b1, 4'h5));
        cyc("adds_clear",   exec_o(3'd0, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4'h5));
        set_in(1'b0, 1'b1, 16'hF704, 4'h0);
        cyc("fetch_b",      fetch_o(1'b1, 4'h0));
        cyc("beq_not",      exec_o(3'd0, 1'b0, 2'd2, 2'd0, 3'd7, 3'd0, 3'd7, 1'b0, 1'b0, 4'h0));

        // ADD S with shift op 3 loads cc=1011 (N,V,C set).
        set_in(1'b0, 1'b1, 16'h0803, 4'hB);
        cyc("fetch_c",      fetch_o(1'b1, 4'h0));
        cyc("add_shift",    exec_o(3'd0, 1'b0, 2'd0, 2'd3, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4'h0));

        // BGE taken (N==V), BHI not taken (C set).
        set_in(1'b0, 1'b1, 16'hFC00, 4'h0);
        cyc("fetch_d",      fetch_o(1'b1, 4'hB));
        cyc("bge_taken",    exec_o(3'd0, 1'b0, 2'd2, 2'd0, 3'd7, 3'd0, 3'd7, 1'b1, 1'b0, 4'hB));
        set_in(1'b0, 1'b1, 16'hF200, 4'h0);
        cyc("fetch_e",      fetch_o(1'b1, 4'hB));
        cyc("bhi_not",      exec_o(3'd0, 1'b0, 2'd2, 2'd0, 3'd7, 3'd0, 3'd7, 1'b0, 1'b0, 4'hB));

        // SUB keeps c_in=0, SBC S passes stored C and loads new flags.
        set_in(1'b0, 1'b1, 16'h4000, 4'h0);
        cyc("fetch_f",      fetch_o(1'b1, 4'hB));
        cyc("sub_cin",      exec_o(3'd2, 1'b0, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4'hB));
        set_in(1'b0, 1'b1, 16'h6800, 4'h6);
        cyc("fetch_g",      fetch_o(1'b1, 4'hB));
        cyc("sbc_cin",      exec_o(3'd3, 1'b1, 2'd0, 2'd0, 3'd0, 3'd0, 3'd0, 1'b1, 1'b0, 4'hB));

        // LD R2,[R3,#1] with two wait cycles.
        set_in(1'b0, 1'b1, 16'hD261, 4'hF);
        cyc("fetch_h",      fetch_o(1'b1, 4'h6));
        cyc("ld_exec",      exec_o(3'd0, 1'b0, 2'd1, 2'd0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 4'h6));
        set_in(1'b0, 1'b0, 16'hD261, 4'hF);
        cyc("ld_wait1",     mem_o(1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 4'h6));
        cyc("ld_wait2",     mem_o(1'b1, 1'b0, 3'd0, 3'd2, 1'b0, 1'b0, 4'h6));
        set_in(1'b0, 1'b1, 16'hD261, 4'hF);
        cyc("ld_done",      mem_o(1'b1, 1'b0, 3'd0, 3'd2, 1'b1, 1'b1, 4'h6));

        // ST aborted by reset mid-MEMORY, then a completed ST.
        set_in(1'b0, 1'b1, 16'hDA61, 4'hF);
        cyc("fetch_i",      fetch_o(1'b1, 4'h6));
        cyc("st_exec",      exec_o(3'd0, 1'b0, 2'd1, 2'd0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 4'h6));
        set_in(1'b0, 1'b0, 16'hDA61, 4'hF);
        cyc("st_wait",      mem_o(1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 4'h6));
        set_in(1'b1, 1'b0, 16'hDA61, 4'hF);
        cyc("st_reset",     fetch_o(1'b0, 4'h0));
        set_in(1'b0, 1'b1, 16'hDA61, 4'hF);
        cyc("fetch_j",      fetch_o(1'b1, 4'h0));
        cyc("st_exec2",     exec_o(3'd0, 1'b0, 2'd1, 2'd0, 3'd3, 3'd0, 3'd0, 1'b0, 1'b1, 4'h0));
        cyc("st_done",      mem_o(1'b0, 1'b1, 3'd2, 3'd0, 1'b0, 1'b0, 4'h0));
        cyc("fetch_end",    fetch_o(1'b1, 4'h0));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
